// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the memory-port sequencer.
package mem_port_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LAT_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// Memory-port sequencer: one req/done access at a time to a synchronous word memory,
// with configurable read/write latency and rejection of misaligned word addresses.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_out
);

  localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WRITE_LAT - 1);

  logic [1:0]        state_reg;
  logic [LAT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              we_reg;
  logic              err_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (addr[1:0] == 2'b00) begin
              addr_reg  <= addr;
              we_reg    <= we;
              wdata_reg <= wdata;
              cnt_reg   <= we ? WR_LOAD : RD_LOAD;
              state_reg <= ACCESS;
            end else begin
              // Misaligned: skip the memory cycle entirely, report through DONE.
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        ACCESS: begin
          if (cnt_reg == '0) begin
            if (!we_reg) rdata_reg <= mem_rdata;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode from registers only, so an asynchronous reset drops them immediately.
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = (state_reg == DONE) && err_reg;
  assign mem_wr    = (state_reg == ACCESS) && we_reg && (cnt_reg == WR_LOAD);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;
  assign state_out = state_reg;

endmodule
